// File: rtl/seq_mul_div_if.sv
// Request/result bundle for the iterative multiply/divide unit.
// Handshake: start is taken only while the unit is idle (busy low); op/a/b are
// captured on that edge, and done pulses for one cycle when results are valid.
interface seq_mul_div_if #(parameter int WIDTH = 8);
  logic                 start;
  logic                 op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;
  logic [1:0]           state;

  modport master (
    output start, op, a, b,
    input  busy, done, product, quotient, remainder, div_by_zero, state
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, product, quotient, remainder, div_by_zero, state
  );
endinterface

// File: rtl/seq_mul_div.sv
// Iterative unsigned unit: shift-add multiply (LSB first) or restoring divide
// (MSB first), one bit per cycle over WIDTH cycles, registered results.
module seq_mul_div #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  seq_mul_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt;
  logic               op_q;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic               last_step;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quot;

  assign last_step = (cnt == CW'(WIDTH - 1));

  // Multiply: the upper half of acc is the running sum, shifted right each step.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: upper half of acc holds the partial remainder; opa shifts the
  // dividend out at the top and the quotient bits in at the bottom.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opb};
  assign div_ok    = ~div_trial[WIDTH];
  assign div_rem   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quot  = {opa[WIDTH-2:0], div_ok};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      op_q            <= 1'b0;
      opa             <= '0;
      opb             <= '0;
      acc             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.product     <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.busy <= (state_d != IDLE);
      bus.done <= (state_d == DONE);
      if (state_q == IDLE && bus.start) begin
        op_q <= bus.op;
        opa  <= bus.a;
        opb  <= bus.b;
        acc  <= '0;
        cnt  <= '0;
      end else if (state_q == CALC) begin
        cnt <= cnt + CW'(1);
        if (!op_q) begin
          acc <= mul_next;
          opb <= opb >> 1;
          if (last_step) begin
            bus.product     <= mul_next;
            bus.div_by_zero <= 1'b0;
          end
        end else begin
          acc <= {div_rem, acc[WIDTH-1:0]};
          opa <= div_quot;
          if (last_step) begin
            bus.quotient    <= div_quot;
            bus.remainder   <= div_rem;
            bus.div_by_zero <= (opb == '0);
          end
        end
      end
    end
  end

  assign bus.state = state_q;
endmodule

// File: tb/tb_seq_mul_div.sv
// Bench for seq_mul_div: directed scenarios plus back-to-back random traffic,
// checked against a reference model through an expected-result queue.
module tb_seq_mul_div;
  localparam int W  = 8;
  localparam int EW = 4 * W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [EW-1:0]    exp_q[$];
  logic [2*W-1:0]   m_prod = '0;
  logic [W-1:0]     m_quot = '0;
  logic [W-1:0]     m_rem = '0;
  logic             m_dbz = 1'b0;

  seq_mul_div_if #(.WIDTH(W)) bus ();
  seq_mul_div #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: results not touched by an operation keep their old value.
  task automatic model_push(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (!op) begin
      m_prod = (2*W)'(a) * (2*W)'(b);
      m_dbz  = 1'b0;
    end else begin
      if (b == '0) begin
        m_quot = '1;
        m_rem  = a;
      end else begin
        m_quot = a / b;
        m_rem  = a % b;
      end
      m_dbz = (b == '0);
    end
    exp_q.push_back({m_dbz, m_rem, m_quot, m_prod});
  endtask

  // Returns one tick after edge E0 with start already dropped.
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    model_push(op, a, b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom_range(0, 1));
    bus.a     = W'($urandom_range(0, 255));
    bus.b     = W'($urandom_range(0, 255));
  endtask

  // lat counts edges from E0 inclusive until done is seen.
  task automatic wait_done(output int lat, output bit timed_out);
    lat = 1;
    timed_out = 1'b1;
    for (int i = 0; i < 4 * W; i++) begin
      if (bus.done) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [EW+3:0] got;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.state, bus.busy, bus.done, bus.div_by_zero, bus.remainder, bus.quotient, bus.product};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_state: got %h expected 0", got);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_multiply();
    int lat; bit to; logic [EW-1:0] e, got;
    issue(1'b0, 8'd5, 8'd5);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL mul_busy: got %b expected 1", bus.busy);
    end
    wait_done(lat, to);
    checks++;
    if (to || lat != W + 1) begin
      failures++;
      $display("FAIL mul_latency: got %0d (timeout %0d) expected %0d", lat, to, W + 1);
    end
    e = exp_q.pop_front();
    got = {bus.div_by_zero, bus.remainder, bus.quotient, bus.product};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL mul_5x5: got %h expected %h", got, e);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL mul_after_done: got busy=%b done=%b expected busy=0 done=0", bus.busy, bus.done);
    end
  endtask

  task automatic test_divide();
    int lat; bit to; logic [EW-1:0] e, got;
    issue(1'b1, 8'd15, 8'd3);
    wait_done(lat, to);
    e = exp_q.pop_front();
    got = {bus.div_by_zero, bus.remainder, bus.quotient, bus.product};
    checks++;
    if (to || got !== e) begin
      failures++;
      $display("FAIL div_15_3: got %h (timeout %0d) expected %h", got, to, e);
    end
    issue(1'b1, 8'd200, 8'd7);
    wait_done(lat, to);
    e = exp_q.pop_front();
    got = {bus.div_by_zero, bus.remainder, bus.quotient, bus.product};
    checks++;
    if (to || got !== e) begin
      failures++;
      $display("FAIL div_200_7: got %h (timeout %0d) expected %h", got, to, e);
    end
    checks++;
    if (bus.quotient !== 8'd28 || bus.remainder !== 8'd4 || bus.product !== 16'd25) begin
      failures++;
      $display("FAIL div_values: got q=%0d r=%0d p=%0d expected q=28 r=4 p=25",
               bus.quotient, bus.remainder, bus.product);
    end
  endtask

  task automatic test_extremes();
    int lat; bit to; logic [EW-1:0] e, got;
    issue(1'b0, 8'd255, 8'd255);
    wait_done(lat, to);
    e = exp_q.pop_front();
    got = {bus.div_by_zero, bus.remainder, bus.quotient, bus.product};
    checks++;
    if (to || got !== e || bus.product !== 16'hFE01) begin
      failures++;
      $display("FAIL mul_255x255: got %h (timeout %0d) expected %h", got, to, e);
    end
    issue(1'b1, 8'd255, 8'd1);
    wait_done(lat, to);
    e = exp_q.pop_front();
    got = {bus.div_by_zero, bus.remainder, bus.quotient, bus.product};
    checks++;
    if (to || got !== e) begin
      failures++;
      $display("FAIL div_255_1: got %h (timeout %0d) expected %h", got, to, e);
    end
  endtask

  task automatic test_div_by_zero();
    int lat; bit to; logic [EW-1:0] e, got;
    issue(1'b1, 8'd9, 8'd0);
    wait_done(lat, to);
    e = exp_q.pop_front();
    got = {bus.div_by_zero, bus.remainder, bus.quotient, bus.product};
    checks++;
    if (to || got !== e) begin
      failures++;
      $display("FAIL div_9_0: got %h (timeout %0d) expected %h", got, to, e);
    end
    checks++;
    if (bus.div_by_zero !== 1'b1 || bus.quotient !== 8'd255 || bus.remainder !== 8'd9) begin
      failures++;
      $display("FAIL dbz_flags: got dbz=%b q=%0d r=%0d expected dbz=1 q=255 r=9",
               bus.div_by_zero, bus.quotient, bus.remainder);
    end
    issue(1'b0, 8'd3, 8'd4);
    wait_done(lat, to);
    e = exp_q.pop_front();
    got = {bus.div_by_zero, bus.remainder, bus.quotient, bus.product};
    checks++;
    if (to || got !== e) begin
      failures++;
      $display("FAIL mul_after_dbz: got %h (timeout %0d) expected %h", got, to, e);
    end
  endtask

  task automatic test_start_during_calc();
    int n_done; logic [EW-1:0] e, got;
    n_done = 0;
    issue(1'b0, 8'd7, 8'd6);
    e = exp_q.pop_front();
    for (int i = 1; i <= 3 * (W + 2); i++) begin
      if (i == 3) begin
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 8'd2; bus.b = 8'd2;
      end
      if (i == 4) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin
        if (n_done == 0) begin
          got = {bus.div_by_zero, bus.remainder, bus.quotient, bus.product};
          checks++;
          if (got !== e) begin
            failures++;
            $display("FAIL ignore_start_result: got %h expected %h", got, e);
          end
        end
        n_done++;
      end
    end
    checks++;
    if (n_done != 1) begin
      failures++;
      $display("FAIL ignore_start_done_count: got %0d expected 1", n_done);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.state !== 2'd0) begin
      failures++;
      $display("FAIL ignore_start_idle: got busy=%b state=%0d expected busy=0 state=0", bus.busy, bus.state);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat; int n_done; bit to; logic [EW+3:0] z; logic [EW-1:0] e, got;
    issue(1'b0, 8'd5, 8'd5);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    z = {bus.state, bus.busy, bus.done, bus.div_by_zero, bus.remainder, bus.quotient, bus.product};
    checks++;
    if (z !== '0) begin
      failures++;
      $display("FAIL reset_mid_calc: got %h expected 0", z);
    end
    exp_q.delete();
    m_prod = '0; m_quot = '0; m_rem = '0; m_dbz = 1'b0;
    n_done = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d expected 0", n_done);
    end
    issue(1'b0, 8'd5, 8'd5);
    wait_done(lat, to);
    checks++;
    if (to || lat != W + 1) begin
      failures++;
      $display("FAIL reset_rerun_latency: got %0d (timeout %0d) expected %0d", lat, to, W + 1);
    end
    e = exp_q.pop_front();
    got = {bus.div_by_zero, bus.remainder, bus.quotient, bus.product};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL reset_rerun_result: got %h expected %h", got, e);
    end
  endtask

  task automatic test_back_to_back();
    int lat; int prev; bit to; logic [EW-1:0] e, got;
    prev = -1;
    @(posedge clk); #1;
    bus.op = 1'($urandom_range(0, 1));
    bus.a  = W'($urandom_range(0, 255));
    bus.b  = W'($urandom_range(0, 255));
    bus.start = 1'b1;
    model_push(bus.op, bus.a, bus.b);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      wait_done(lat, to);
      e = exp_q.pop_front();
      got = {bus.div_by_zero, bus.remainder, bus.quotient, bus.product};
      checks++;
      if (to || got !== e) begin
        failures++;
        $display("FAIL b2b_result_%0d: got %h (timeout %0d) expected %h", k, got, to, e);
      end
      if (k > 0) begin
        checks++;
        if (cyc - prev != W + 2) begin
          failures++;
          $display("FAIL b2b_spacing_%0d: got %0d expected %0d", k, cyc - prev, W + 2);
        end
      end
      prev = cyc;
      if (k < 3) begin
        bus.op = 1'($urandom_range(0, 1));
        bus.a  = W'($urandom_range(0, 255));
        bus.b  = W'($urandom_range(0, 255));
        model_push(bus.op, bus.a, bus.b);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_extremes();
    test_div_by_zero();
    test_start_during_calc();
    test_reset_mid_calc();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
